// File: rtl/ah_burst_arbiter_4_if.sv
// Request/grant bundle between requesters, the shared resource and the burst arbiter.
// Master drives requests and beat acceptance; slave (the arbiter) drives registered grant outputs.
interface ah_burst_arbiter_4_if #(
    parameter int LEN_W = 4
);
    logic [3:0]         req;
    logic [4*LEN_W-1:0] req_len;
    logic               gnt_busy;
    logic               beat_ack;
    logic [3:0]         gnt;
    logic [1:0]         gnt_id;
    logic               burst_done;
    logic [LEN_W-1:0]   beats_left;

    modport master (
        output req, req_len, gnt_busy, beat_ack,
        input  gnt, gnt_id, burst_done, beats_left
    );

    modport slave (
        input  req, req_len, gnt_busy, beat_ack,
        output gnt, gnt_id, burst_done, beats_left
    );
endinterface

// File: rtl/ah_burst_arbiter_4.sv
// 4-way round-robin burst arbiter; grant appears 1 cycle after the winning edge, burst_done 1 cycle after the end.
// Backpressure: gnt_busy holds off new grants in IDLE only; beat_ack paces beats, a dropped req aborts the burst.
module ah_burst_arbiter_4 #(
    parameter int LEN_W = 4
) (
    input  logic               clk,
    input  logic               rstn,
    ah_burst_arbiter_4_if.slave bus
);

    typedef enum logic {
        IDLE,
        BURST
    } state_t;

    state_t           state_q, state_d;
    logic [3:0]       gnt_q, gnt_d;
    logic [1:0]       gnt_id_q, gnt_id_d;
    logic             burst_done_q, burst_done_d;
    logic [LEN_W-1:0] beats_left_q, beats_left_d;
    logic [1:0]       last_ptr_q, last_ptr_d;

    logic             win_vld;
    logic [1:0]       win_id;
    logic             burst_end;

    // Search upward from the requester after the last owner; k == 4 wraps back to the last owner itself.
    always_comb begin
        win_vld = 1'b0;
        win_id  = 2'd0;
        for (int k = 1; k <= 4; k++) begin
            if (!win_vld && bus.req[last_ptr_q + 2'(k)]) begin
                win_vld = 1'b1;
                win_id  = last_ptr_q + 2'(k);
            end
        end
    end

    // A final ack and a dropped request in the same cycle collapse into one end.
    assign burst_end = (bus.beat_ack && (beats_left_q == '0)) || !bus.req[gnt_id_q];

    always_comb begin
        state_d      = state_q;
        gnt_d        = gnt_q;
        gnt_id_d     = gnt_id_q;
        burst_done_d = 1'b0;
        beats_left_d = beats_left_q;
        last_ptr_d   = last_ptr_q;
        unique case (state_q)
            IDLE: begin
                if (win_vld && !bus.gnt_busy) begin
                    state_d      = BURST;
                    gnt_d        = 4'b0001 << win_id;
                    gnt_id_d     = win_id;
                    beats_left_d = bus.req_len[win_id*LEN_W +: LEN_W];
                end
            end
            BURST: begin
                if (burst_end) begin
                    state_d      = IDLE;
                    gnt_d        = 4'b0000;
                    burst_done_d = 1'b1;
                    beats_left_d = '0;
                    last_ptr_d   = gnt_id_q;
                end else if (bus.beat_ack) begin
                    beats_left_d = beats_left_q - 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q      <= IDLE;
            gnt_q        <= 4'b0000;
            gnt_id_q     <= 2'd0;
            burst_done_q <= 1'b0;
            beats_left_q <= '0;
            last_ptr_q   <= 2'd3;
        end else begin
            state_q      <= state_d;
            gnt_q        <= gnt_d;
            gnt_id_q     <= gnt_id_d;
            burst_done_q <= burst_done_d;
            beats_left_q <= beats_left_d;
            last_ptr_q   <= last_ptr_d;
        end
    end

    assign bus.gnt        = gnt_q;
    assign bus.gnt_id     = gnt_id_q;
    assign bus.burst_done = burst_done_q;
    assign bus.beats_left = beats_left_q;

endmodule

// File: tb/tb_ah_burst_arbiter_4.sv
// Bench for ah_burst_arbiter_4: directed scenarios plus random traffic against a transaction-level model.
module tb_ah_burst_arbiter_4;

    logic clk  = 1'b0;
    logic rstn = 1'b1;
    int   cyc  = 0;
    int   tests_run    = 0;
    int   tests_failed = 0;

    ah_burst_arbiter_4_if #(.LEN_W(4)) bus ();

    ah_burst_arbiter_4 #(.LEN_W(4)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         cyc;
        logic [3:0] gnt;
        logic [1:0] id;
        logic [3:0] beats;
        logic       done;
    } exp_t;

    exp_t q[$];
    int   grant_log[$];

    // Reference model: which requester owns the resource and how many beats it still owes.
    bit m_active;
    int m_id;
    int m_rem;
    int m_last;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        tests_run++;
        if (act !== req) begin
            tests_failed++;
            $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic model_step();
        bit done;
        done = 1'b0;
        if (!m_active) begin
            if (bus.req != 4'b0000 && !bus.gnt_busy) begin
                for (int k = 1; k <= 4; k++) begin
                    int w;
                    w = (m_last + k) % 4;
                    if (!m_active && bus.req[w]) begin
                        m_active = 1'b1;
                        m_id     = w;
                        m_rem    = int'((bus.req_len >> (4 * w)) & 16'h000F);
                    end
                end
            end
        end else if ((bus.beat_ack && m_rem == 0) || !bus.req[m_id]) begin
            m_active = 1'b0;
            m_last   = m_id;
            done     = 1'b1;
        end else if (bus.beat_ack) begin
            m_rem = m_rem - 1;
        end
        if (m_active || done) begin
            exp_t e;
            e.cyc   = cyc + 1;
            e.gnt   = m_active ? 4'(1 << m_id) : 4'b0000;
            e.id    = 2'(m_id);
            e.beats = 4'(m_rem);
            e.done  = done;
            q.push_back(e);
        end
    endtask

    task automatic step();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rstn     = 1'b0;
        m_active = 1'b0;
        m_last   = 3;
        while (q.size() > 0 && q[$].cyc >= cyc) void'(q.pop_back());
        #1;
        chk("rst_gnt", 32'(bus.gnt), 32'h0);
        chk("rst_gnt_id", 32'(bus.gnt_id), 32'h0);
        chk("rst_burst_done", 32'(bus.burst_done), 32'h0);
        chk("rst_beats_left", 32'(bus.beats_left), 32'h0);
        @(posedge clk);
        #1;
        rstn = 1'b1;
    endtask

    // Monitor: pops an expectation whenever the arbiter presents a grant or a done pulse.
    logic [3:0] prev_gnt = 4'b0000;
    always @(negedge clk) begin
        if (!rstn) begin
            prev_gnt = 4'b0000;
        end else begin
            tests_run++;
            if (!$onehot0(bus.gnt)) begin
                tests_failed++;
                $display("FAIL gnt_onehot: got %b, required at most one bit", bus.gnt);
            end
            if (bus.gnt != 4'b0000 || bus.burst_done) begin
                tests_run++;
                if (q.size() == 0) begin
                    tests_failed++;
                    $display("FAIL unexpected_output: got gnt=%b done=%b beats=%0d at cycle %0d, required idle",
                             bus.gnt, bus.burst_done, bus.beats_left, cyc);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    if (e.cyc != cyc || e.gnt !== bus.gnt || e.done !== bus.burst_done ||
                        (e.gnt != 4'b0000 && (e.beats !== bus.beats_left || e.id !== bus.gnt_id))) begin
                        tests_failed++;
                        $display("FAIL scoreboard: got cyc=%0d gnt=%b id=%0d beats=%0d done=%b, required cyc=%0d gnt=%b id=%0d beats=%0d done=%b",
                                 cyc, bus.gnt, bus.gnt_id, bus.beats_left, bus.burst_done,
                                 e.cyc, e.gnt, e.id, e.beats, e.done);
                    end
                end
            end else if (q.size() > 0 && q[0].cyc <= cyc) begin
                tests_run++;
                tests_failed++;
                $display("FAIL missing_output: got idle at cycle %0d, required gnt=%b done=%b at cycle %0d",
                         cyc, q[0].gnt, q[0].done, q[0].cyc);
                void'(q.pop_front());
            end
            if (bus.gnt != 4'b0000 && prev_gnt == 4'b0000) grant_log.push_back(int'(bus.gnt_id));
            prev_gnt = bus.gnt;
        end
    end

    initial begin
        int order [5];
        int acks;
        bit done_seen;
        bus.req      = 4'b0000;
        bus.req_len  = 16'h0000;
        bus.gnt_busy = 1'b0;
        bus.beat_ack = 1'b0;
        #1;
        do_reset();

        // Three-beat burst to requester 1 with continuous acks.
        bus.req = 4'b1010;
        bus.req_len = 16'h7020;
        bus.beat_ack = 1'b1;
        for (int i = 0; i < 5; i++) step();
        bus.req = 4'b0000;
        for (int i = 0; i < 3; i++) step();

        // All requesting, one-beat bursts: strict rotation with idle gaps.
        do_reset();
        grant_log.delete();
        bus.req = 4'b1111;
        bus.req_len = 16'h0000;
        bus.beat_ack = 1'b1;
        for (int i = 0; i < 10; i++) step();
        order = '{0, 1, 2, 3, 0};
        chk("rr_count", 32'(grant_log.size() >= 5), 32'h1);
        for (int i = 0; i < 5 && i < grant_log.size(); i++) chk("rr_order", 32'(grant_log[i]), 32'(order[i]));
        bus.req = 4'b0000;
        for (int i = 0; i < 3; i++) step();

        // gnt_busy holds off a lone requester.
        bus.req = 4'b0100;
        bus.req_len = 16'h0000;
        bus.beat_ack = 1'b0;
        bus.gnt_busy = 1'b1;
        for (int i = 0; i < 5; i++) step();
        chk("busy_hold_gnt", 32'(bus.gnt), 32'h0);
        bus.gnt_busy = 1'b0;
        step();
        chk("busy_release_gnt", 32'(bus.gnt), 32'h4);
        bus.gnt_busy = 1'b1;
        bus.beat_ack = 1'b1;
        step();
        bus.req = 4'b0000;
        bus.gnt_busy = 1'b0;
        for (int i = 0; i < 2; i++) step();

        // Abort of requester 3 after two acks; next search starts at requester 0.
        do_reset();
        bus.req = 4'b1000;
        bus.req_len = 16'h5000;
        bus.beat_ack = 1'b0;
        step();
        bus.req_len = 16'h0000;
        bus.beat_ack = 1'b1;
        step();
        step();
        bus.req = 4'b0111;
        bus.beat_ack = 1'b0;
        step();
        step();
        chk("abort_next_winner", 32'(bus.gnt), 32'h1);
        bus.req = 4'b0000;
        for (int i = 0; i < 2; i++) step();

        // Reset in the middle of a burst with three beats remaining.
        do_reset();
        bus.req = 4'b1111;
        bus.req_len = 16'h0005;
        bus.beat_ack = 1'b1;
        for (int i = 0; i < 3; i++) step();
        chk("pre_reset_beats", 32'(bus.beats_left), 32'h3);
        do_reset();
        bus.req_len = 16'h0000;
        step();
        chk("post_reset_winner", 32'(bus.gnt), 32'h1);
        bus.req = 4'b0000;
        for (int i = 0; i < 2; i++) step();

        // Longest burst with acks every other cycle: exactly 16 beats.
        do_reset();
        bus.req = 4'b0001;
        bus.req_len = 16'h000F;
        bus.beat_ack = 1'b0;
        step();
        acks = 0;
        done_seen = 1'b0;
        for (int i = 0; i < 80 && !done_seen; i++) begin
            bus.beat_ack = (i % 2 == 1);
            if (bus.gnt != 4'b0000 && bus.beat_ack) acks++;
            step();
            if (bus.burst_done) done_seen = 1'b1;
        end
        chk("long_done_seen", 32'(done_seen), 32'h1);
        chk("long_beat_count", 32'(acks), 32'd16);
        bus.req = 4'b0000;
        for (int i = 0; i < 3; i++) step();

        // Random traffic, including occasional resets.
        do_reset();
        for (int c = 0; c < 1500; c++) begin
            if ($urandom_range(0, 3) == 0) bus.req = 4'($urandom);
            bus.req_len  = 16'($urandom);
            bus.gnt_busy = ($urandom_range(0, 3) == 0);
            bus.beat_ack = ($urandom_range(0, 1) == 1);
            if ($urandom_range(0, 299) == 0) do_reset();
            else step();
        end
        bus.req = 4'b0000;
        for (int i = 0; i < 3; i++) step();
        chk("scoreboard_drained", 32'(q.size()), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish, required completion");
        $fatal(1, "timeout");
    end

endmodule
